rx_rs232: RTL
=============

// Module: rx_rs232
// PURPOSE
//   Serial receiver: the downstream partner of the UART transmitter in the RS232 link.
//   Deserialises one 11-bit frame: 0-START, 1..8 DATA (LSB first), 9 MARK (always 1), 10-STOP.
//   Delivers each received byte as a one-cycle valid pulse. Flags frames whose bit 9 or stop bit is not 1.
//   Bit timing is identical to the transmitter: CLK_PER_BIT clocks per bit, with no baud tolerance tracking.
// PARAMETERS
//   CLK_PER_BIT  5208  clocks per bit (9600 bps at 50 MHz); sim value 12; must be >= 8
//   CNT_W        13    bit-counter width; must satisfy 2**CNT_W > CLK_PER_BIT
// PORTS
//   clk_s    in   1  system clock; single clock domain
//   rstn_s   in   1  reset, asynchronous, active-low
//   iRX      in   1  serial line, asynchronous to clk_s, idle high
//   oDATA    out  8  last good byte; holds its value until the next good frame
//   oVALID   out  1  1-cycle pulse when a good byte is loaded into oDATA
//   oERR     out  1  1-cycle pulse on a framing error (MARK or STOP sampled 0)
//   oBUSY    out  1  high from the start-edge detect until the frame ends or is rejected
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE, counters 0, oDATA=8'h00, oVALID=0, oERR=0,
//     oBUSY=0, synchroniser flops preset to 1.
//   Input path: 2-FF synchroniser, then a 3rd flop for edge detection. Start edge = sync 1->0.
//   Sample point: MID = CLK_PER_BIT/2 - 1 (integer division) within each bit. Bit counter cnt counts 0..CLK_PER_BIT-1.
//   FSM:
//     IDLE : on start edge, clear cnt, set oBUSY=1, go to START.
//     START: when cnt==MID, take a sample. If the sample is 1, treat it as a glitch: go to IDLE with oBUSY=0 and no pulse.
//            If the sample is 0, clear cnt, set bitidx=0, go to DATA.
//     DATA : when cnt==CLK_PER_BIT-1 (one bit later, mid of the next bit), shift the sample into the shift register MSB (right shift).
//            At the same point bitidx++ and cnt clears. After the 8th sample, go to MARK.
//     MARK : when cnt==CLK_PER_BIT-1, latch the sample into mark_ok, then go to STOP.
//     STOP : when cnt==CLK_PER_BIT-1, sample the stop bit.
//            If mark_ok and the stop bit are both 1: on the next edge oDATA<=shreg and oVALID=1.
//            Otherwise: oERR=1 and oDATA is unchanged.
//            In both cases go to IDLE and set oBUSY=0.
//   Exit timing: IDLE is re-entered at mid-stop, so a start edge arriving half a bit later is caught.
//     Back-to-back frames are therefore received with no gap.
//   Latency: the oVALID/oERR pulse occurs 10*CLK_PER_BIT + MID + 4 clocks after the iRX falling edge.
//     This includes 2 sync clocks, 1 edge-detect clock and 1 output-register clock.
//   Line held low after an error: no new frame starts until iRX returns high and falls again. Breaks produce exactly one oERR.
//   oVALID and oERR are mutually exclusive and never assert in consecutive cycles for a single frame.
//   Reset mid-frame: the frame is abandoned immediately. No pulse is emitted, then normal reset values apply.
// CONFIGURATION
//   RX_MAJORITY_VOTE_EN defined: each bit is the 2-of-3 majority of the synchronised samples at cnt==S-1, S and S+1.
//     S is the normal sample point. The decision is made at S+1, and all state transitions shift 1 clock later.
//     Counters keep the same period, and the latency above increases by 1.
//   RX_MAJORITY_VOTE_EN undefined: a single sample at S, exactly as described in BEHAVIOUR.
// STRUCTURE
//   Package rs232_pkg holds:
//     - frame constants: FRAME_BITS=11, DATA_BITS=8
//     - the state enum {IDLE, START, DATA, MARK, STOP}
//     - default CLK_PER_BIT=5208, shared with the transmitter
//   Sub-module rx_bit_sampler contains the synchroniser, edge detect, optional majority vote and sample strobe.
//     Its outputs are fall_edge, smp_val and smp_stb. The FSM and shift register stay in rx_rs232.
// TESTING  (CLK_PER_BIT=12)
//   1. Send 8'hA5 as a valid frame -> one oVALID pulse, oDATA=8'hA5, oERR stays 0, oBUSY low afterwards.
//   2. Send 8'h00 then 8'hFF back-to-back with no idle gap -> two oVALID pulses carrying 00 then FF.
//   3. Drive a low glitch on iRX for 4 clocks while idle -> no oVALID, no oERR, and oBUSY returns low within 10 clocks.
//   4. Send frame 8'h3C with stop bit=0 -> oERR pulse, oDATA keeps its previous value.
//      Send frame 8'h3C with bit 9=0 -> oERR pulse.
//   5. Assert rstn_s low during data bit 4 of a frame -> outputs read reset values at once.
//      The next valid frame 8'h5A is still received correctly.
//   6. Loopback from the transmitter's serial output to iRX with 8'h81 -> oVALID with 8'h81.
//      With RX_MAJORITY_VOTE_EN, a 1-clock inversion at the sample point of data bit 2 still yields 8'h81.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared RS232 link definitions: frame geometry, receiver state encoding and helpers.
// Used by both the transmitter and the receiver of the link.
package rs232_pkg;

  localparam int FRAME_BITS      = 11;
  localparam int DATA_BITS       = 8;
  localparam int DEF_CLK_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    MARK  = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_rs232_if.sv
// Receiver output bundle: delivered byte, its valid/error pulses and the busy flag.
interface rx_rs232_if;

  logic [rs232_pkg::DATA_BITS-1:0] oDATA;
  logic                            oVALID;
  logic                            oERR;
  logic                            oBUSY;

  modport master (
    output oDATA,
    output oVALID,
    output oERR,
    output oBUSY
  );

  modport slave (
    input  oDATA,
    input  oVALID,
    input  oERR,
    input  oBUSY
  );

endinterface

// File: rtl/rx_bit_sampler.sv
// Serial line front end: synchroniser, start-edge detect, bit-period counter and sample strobe.
// Build option RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 vote of three consecutive samples.
module rx_bit_sampler
  import rs232_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int CNT_W       = 13
)(
  input  logic clk_s,
  input  logic rstn_s,
  input  logic rx_line,
  input  logic cnt_clr,
  input  logic start_ph,
  output logic fall_edge,
  output logic smp_val,
  output logic smp_stb
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLK_PER_BIT / 2 - 1);

`ifdef RX_MAJORITY_VOTE_EN
  // Vote window is S-1..S+1, so the decision lands one clock after the nominal point.
  localparam int               SYNC_N    = 4;
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(CLK_PER_BIT / 2);
`else
  localparam int               SYNC_N    = 3;
  localparam logic [CNT_W-1:0] START_CNT = MID_CNT;
`endif

  logic [SYNC_N-1:0] sync_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;

  // Stages 0/1 form the metastability synchroniser, later stages are history for edge and vote.
  for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
          sync_reg[gi] <= 1'b1;
        end else begin
          sync_reg[gi] <= rx_line;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
          sync_reg[gi] <= 1'b1;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  end

  assign fall_edge = sync_reg[2] & ~sync_reg[1];

`ifdef RX_MAJORITY_VOTE_EN
  assign smp_val = maj3(sync_reg[1], sync_reg[2], sync_reg[3]);
`else
  assign smp_val = sync_reg[1];
`endif

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (cnt_clr || (cnt_reg == LAST_CNT)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // START samples half a bit in; every later bit is one full period after that.
  assign smp_stb = start_ph ? (cnt_reg == START_CNT) : (cnt_reg == LAST_CNT);

endmodule

// File: rtl/rx_rs232.sv
// rx_rs232: RS232 receiver for 11-bit frames (start, 8 data LSB first, mark, stop).
// Build option RX_MAJORITY_VOTE_EN enables 2-of-3 bit voting in rx_bit_sampler.
module rx_rs232
  import rs232_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int CNT_W       = 13
)(
  input  logic       clk_s,
  input  logic       rstn_s,
  input  logic       iRX,
  rx_rs232_if.master rx
);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_START = 3'(START);
  localparam logic [2:0] S_DATA  = 3'(DATA);
  localparam logic [2:0] S_MARK  = 3'(MARK);
  localparam logic [2:0] S_STOP  = 3'(STOP);

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic fall_edge;
  logic smp_val;
  logic smp_stb;
  logic cnt_clr;
  logic start_ph;

  logic [2:0]           state_reg,   state_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shreg_reg,   shreg_next;
  logic                 mark_ok_reg, mark_ok_next;
  logic                 busy_reg,    busy_next;
  logic                 done_reg,    done_next;
  logic                 good_reg,    good_next;
  logic [DATA_BITS-1:0] data_reg,    data_next;
  logic                 valid_reg,   valid_next;
  logic                 err_reg,     err_next;

  rx_bit_sampler #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_sampler (
    .clk_s     (clk_s),
    .rstn_s    (rstn_s),
    .rx_line   (iRX),
    .cnt_clr   (cnt_clr),
    .start_ph  (start_ph),
    .fall_edge (fall_edge),
    .smp_val   (smp_val),
    .smp_stb   (smp_stb)
  );

  assign start_ph = (state_reg == S_START);

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shreg_next   = shreg_reg;
    mark_ok_next = mark_ok_reg;
    busy_next    = busy_reg;
    good_next    = good_reg;
    done_next    = 1'b0;
    cnt_clr      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (fall_edge) begin
          cnt_clr    = 1'b1;
          busy_next  = 1'b1;
          state_next = S_START;
        end
      end

      S_START: begin
        if (smp_stb) begin
          // A high level at mid-start means the falling edge was a glitch.
          if (smp_val) begin
            busy_next  = 1'b0;
            state_next = S_IDLE;
          end else begin
            cnt_clr      = 1'b1;
            bit_idx_next = '0;
            state_next   = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (smp_stb) begin
          shreg_next   = {smp_val, shreg_reg[DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == LAST_IDX) begin
            state_next = S_MARK;
          end
        end
      end

      S_MARK: begin
        if (smp_stb) begin
          mark_ok_next = smp_val;
          state_next   = S_STOP;
        end
      end

      S_STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (smp_stb) begin
          good_next  = mark_ok_reg & smp_val;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
      end

      default: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_next = done_reg & good_reg;
    err_next   = done_reg & ~good_reg;
    data_next  = (done_reg & good_reg) ? shreg_reg : data_reg;
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state_reg   <= S_IDLE;
      bit_idx_reg <= '0;
      shreg_reg   <= '0;
      mark_ok_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      good_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      shreg_reg   <= shreg_next;
      mark_ok_reg <= mark_ok_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      good_reg    <= good_next;
    end
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  assign rx.oDATA  = data_reg;
  assign rx.oVALID = valid_reg;
  assign rx.oERR   = err_reg;
  assign rx.oBUSY  = busy_reg;

endmodule
